// File: rtl/diff_frame_sync_if.sv
// Purpose : bundles the serial input and aligned parallel outputs of diff_frame_sync.
// Latency : n/a (wiring only).
// Backpressure: none; the receive stream runs one bit per clock with no stall path.
// Ports   : en, data_in (to the framer); word, word_valid, frame_start, locked,
//           state, sync_err_cnt (from the framer).
interface diff_frame_sync_if #(
  parameter int WORD_W = 16
);
  logic              en;
  logic              data_in;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              frame_start;
  logic              locked;
  logic [1:0]        state;
  logic [7:0]        sync_err_cnt;

  // master: the side that feeds bits in and consumes aligned words
  modport master (
    output en, data_in,
    input  word, word_valid, frame_start, locked, state, sync_err_cnt
  );

  // slave: the framer itself
  modport slave (
    input  en, data_in,
    output word, word_valid, frame_start, locked, state, sync_err_cnt
  );
endinterface

// File: rtl/diff_frame_sync.sv
// Purpose : serial frame synchroniser; hunts for SYNC_WORD, verifies, locks, emits payload words.
// Latency : word/word_valid appear 1 cycle after the payload-word boundary.
// Backpressure: none; one bit is consumed every clock, outputs are strobes.
// Ports   : clk (recovered rx clock), rst (async, active high), bus (slave modport:
//           en, data_in in; word, word_valid, frame_start, locked, state, sync_err_cnt out).
module diff_frame_sync #(
  parameter int                WORD_W      = 16,
  parameter logic [WORD_W-1:0] SYNC_WORD   = WORD_W'(16'hA55A),
  parameter int                FRAME_WORDS = 4,
  parameter int                LOCK_HITS   = 2,
  parameter int                LOSS_MISSES = 2
) (
  input  logic                clk,
  input  logic                rst,
  diff_frame_sync_if.slave    bus
);
  localparam int PH_W = $clog2(WORD_W);
  localparam int SL_W = $clog2(FRAME_WORDS + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(WORD_W - 1);
  localparam logic [SL_W-1:0] SL_LAST = SL_W'(FRAME_WORDS);
  localparam logic [3:0]      LOCK_N  = 4'(LOCK_HITS);
  localparam logic [3:0]      LOSS_N  = 4'(LOSS_MISSES);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [SL_W-1:0]   slot_q, slot_d, slot_next;
  logic [3:0]        hit_cnt_q, hit_cnt_d, hit_inc;
  logic [3:0]        miss_cnt_q, miss_cnt_d, miss_inc;
  logic [7:0]        sync_err_cnt_q, sync_err_cnt_d;
  logic              word_valid_q, word_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              locked_q, locked_d;
  logic              sync_hit, boundary;

  always_comb begin
    sr_d           = {sr_q[WORD_W-2:0], bus.data_in};
    state_d        = state_q;
    word_d         = word_q;
    phase_d        = phase_q;
    slot_d         = slot_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    sync_err_cnt_d = sync_err_cnt_q;
    word_valid_d   = 1'b0;
    frame_start_d  = 1'b0;

    sync_hit  = (sr_q == SYNC_WORD);
    boundary  = (state_q != ST_HUNT) && (phase_q == PH_LAST);
    slot_next = (slot_q == SL_LAST) ? '0 : slot_q + 1'b1;
    hit_inc   = hit_cnt_q + 4'd1;
    miss_inc  = miss_cnt_q + 4'd1;

    if (!bus.en) begin
      state_d    = ST_HUNT;
      phase_d    = '0;
      slot_d     = '0;
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      // Word phase free-runs once aligned; a HUNT match below re-seeds it.
      if (state_q != ST_HUNT) begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      end

      case (state_q)
        ST_HUNT: begin
          if (sync_hit) begin
            // sr already holds the sync word, so the next word completes WORD_W cycles later.
            slot_d    = SL_W'(1);
            phase_d   = '0;
            hit_cnt_d = 4'd1;
            if (LOCK_HITS == 1) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = '0;
            end else begin
              state_d = ST_VERIFY;
            end
          end
        end

        ST_VERIFY: begin
          if (boundary) begin
            slot_d = slot_next;
            if (slot_q == '0) begin
              if (sync_hit) begin
                hit_cnt_d = hit_inc;
                if (hit_inc == LOCK_N) begin
                  state_d    = ST_LOCKED;
                  miss_cnt_d = '0;
                end
              end else begin
                state_d   = ST_HUNT;
                hit_cnt_d = '0;
              end
            end
          end
        end

        ST_LOCKED: begin
          if (boundary) begin
            slot_d = slot_next;
            if (slot_q == '0) begin
              if (sync_hit) begin
                miss_cnt_d = '0;
              end else begin
                miss_cnt_d = miss_inc;
                if (sync_err_cnt_q != 8'hFF) begin
                  sync_err_cnt_d = sync_err_cnt_q + 8'd1;
                end
                if (miss_inc == LOSS_N) begin
                  state_d    = ST_HUNT;
                  hit_cnt_d  = '0;
                  miss_cnt_d = '0;
                end
              end
            end else begin
              word_d        = sr_q;
              word_valid_d  = 1'b1;
              frame_start_d = (slot_q == SL_W'(1));
            end
          end
        end

        default: state_d = ST_HUNT;
      endcase
    end

    // Registered off the next state so locked tracks state on the same edge.
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_HUNT;
      sr_q           <= '0;
      word_q         <= '0;
      phase_q        <= '0;
      slot_q         <= '0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
      sync_err_cnt_q <= '0;
      word_valid_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      word_q         <= word_d;
      phase_q        <= phase_d;
      slot_q         <= slot_d;
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      sync_err_cnt_q <= sync_err_cnt_d;
      word_valid_q   <= word_valid_d;
      frame_start_q  <= frame_start_d;
      locked_q       <= locked_d;
    end
  end

  assign bus.word         = word_q;
  assign bus.word_valid   = word_valid_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.locked       = locked_q;
  assign bus.state        = state_q;
  assign bus.sync_err_cnt = sync_err_cnt_q;
endmodule

// File: tb/tb_diff_frame_sync.sv
module tb_diff_frame_sync;
  localparam logic [15:0] SYNC = 16'hA55A;
  localparam logic [15:0] BAD  = 16'hA55B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic data_in = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  diff_frame_sync_if #(.WORD_W(16)) if0 ();
  diff_frame_sync_if #(.WORD_W(16)) if1 ();
  assign if0.en = en;
  assign if0.data_in = data_in;
  assign if1.en = en;
  assign if1.data_in = data_in;

  diff_frame_sync dut0 (.clk(clk), .rst(rst), .bus(if0));
  diff_frame_sync #(.LOSS_MISSES(15)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // ---------------- behavioural model ----------------
  // Alignment is tracked as an anchor time: the cycle the sync word was found.
  // Every multiple of 16 cycles after it is a word boundary; boundary k lands in slot k mod 5.
  int          m_mode [2];   // 0 hunt, 1 verify, 2 locked
  longint      m_anchor [2];
  int          m_hits [2];
  int          m_miss [2];
  int          m_err [2];
  logic [15:0] m_word [2];
  bit          m_vld [2];
  bit          m_fs [2];
  logic [15:0] m_sr;
  longint      m_cyc = 0;

  function automatic int loss_of(input int k);
    return (k == 0) ? 2 : 15;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_anchor[k] = 0; m_hits[k] = 0; m_miss[k] = 0; m_err[k] = 0;
      m_word[k] = 16'h0; m_vld[k] = 1'b0; m_fs[k] = 1'b0;
    end
    m_sr = 16'h0;
  endtask

  task automatic model_step();
    longint d;
    int slot;
    m_cyc++;
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = 1'b0;
      m_fs[k]  = 1'b0;
      if (!en) begin
        m_mode[k] = 0; m_hits[k] = 0; m_miss[k] = 0;
      end else if (m_mode[k] == 0) begin
        if (m_sr == SYNC) begin
          m_anchor[k] = m_cyc; m_hits[k] = 1; m_mode[k] = 1;
        end
      end else begin
        d = m_cyc - m_anchor[k];
        if (d % 16 == 0) begin
          slot = int'((d / 16) % 5);
          if (slot == 0) begin
            if (m_mode[k] == 1) begin
              if (m_sr == SYNC) begin
                m_hits[k]++;
                if (m_hits[k] == 2) begin m_mode[k] = 2; m_miss[k] = 0; end
              end else begin
                m_mode[k] = 0; m_hits[k] = 0;
              end
            end else if (m_sr == SYNC) begin
              m_miss[k] = 0;
            end else begin
              m_miss[k]++;
              if (m_err[k] < 255) m_err[k]++;
              if (m_miss[k] == loss_of(k)) begin m_mode[k] = 0; m_miss[k] = 0; end
            end
          end else if (m_mode[k] == 2) begin
            m_word[k] = m_sr; m_vld[k] = 1'b1; m_fs[k] = (slot == 1);
          end
        end
      end
    end
    m_sr = {m_sr[14:0], data_in};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  int          vld_cnt0 = 0;
  logic [15:0] cap0 [$];

  task automatic cmp_inst(input int k, input logic [15:0] w, input logic v, input logic fs,
                          input logic lk, input logic [1:0] st, input logic [7:0] e);
    logic [29:0] act, exp;
    act = {w, v, fs, lk, st, e};
    exp = {m_word[k], m_vld[k], m_fs[k], (m_mode[k] == 2), 2'(m_mode[k]), 8'(m_err[k])};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle_dut%0d t=%0t: got {word,vld,fs,lk,st,err}=%h expected %h",
               k, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_inst(0, if0.word, if0.word_valid, if0.frame_start, if0.locked, if0.state, if0.sync_err_cnt);
      cmp_inst(1, if1.word, if1.word_valid, if1.frame_start, if1.locked, if1.state, if1.sync_err_cnt);
      if (if0.word_valid === 1'b1) begin
        vld_cnt0++;
        cap0.push_back(if0.word);
      end
    end
  end

  // ---------------- literal checks and drivers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_words(input string name);
    chk({name, "_count"}, 32'(cap0.size()), 32'd8);
    for (int i = 0; i < cap0.size() && i < 8; i++)
      chk({name, "_word"}, 32'(cap0[i]), 32'((i % 4) + 1));
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_frame(input logic [15:0] s);
    send_word(s);
    for (int i = 1; i <= 4; i++) send_word(16'(i));
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b0);
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    data_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cap0.delete();
    vld_cnt0 = 0;
  endtask

  logic [79:0] fr;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word", 32'(if0.word), 32'h0);
    chk("rst_state", 32'(if0.state), 32'h0);
    chk("rst_locked", 32'(if0.locked), 32'h0);
    chk("rst_err", 32'(if1.sync_err_cnt), 32'h0);
    rst = 1'b0;
    idle(4);

    // lock-up: three frames, checks at fixed bit counts
    hard_reset();
    fr = {SYNC, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    for (int i = 0; i < 240; i++) begin
      send_bit(fr[79 - (i % 80)]);
      case (i + 1)
        16:  chk("lock_hunt_before_match", 32'(if0.state), 32'd0);
        17:  chk("lock_verify_after_sync1", 32'(if0.state), 32'd1);
        96:  chk("lock_verify_before_sync2", 32'(if0.state), 32'd1);
        97:  begin
               chk("lock_state_locked", 32'(if0.state), 32'd2);
               chk("lock_locked_flag", 32'(if0.locked), 32'd1);
             end
        112: chk("lock_no_valid_early", 32'(if0.word_valid), 32'd0);
        113: chk("lock_first_word", {if0.word, 14'd0, if0.word_valid, if0.frame_start}, {16'h0001, 14'd0, 2'b11});
        114: chk("lock_valid_single", 32'(if0.word_valid), 32'd0);
        129: chk("lock_second_word", {if0.word, 14'd0, if0.word_valid, if0.frame_start}, {16'h0002, 14'd0, 2'b10});
        default: ;
      endcase
    end
    idle(20);
    chk_words("lock_words");

    // verify failure
    hard_reset();
    send_frame(SYNC);
    chk("vfail_verify", 32'(if0.state), 32'd1);
    send_frame(BAD);
    chk("vfail_hunt", 32'(if0.state), 32'd0);
    idle(20);
    chk("vfail_no_valid", 32'(vld_cnt0), 32'd0);
    chk("vfail_err", 32'(if0.sync_err_cnt), 32'd0);

    // lock loss
    hard_reset();
    send_frame(SYNC);
    send_frame(SYNC);
    chk("loss_locked", 32'(if0.locked), 32'd1);
    send_frame(BAD);
    chk("loss_one_miss", {24'd0, if0.sync_err_cnt}, 32'd1);
    chk("loss_still_locked", 32'(if0.locked), 32'd1);
    send_frame(SYNC);
    send_frame(BAD);
    chk("loss_miss_reset", {if0.locked, 23'd0, if0.sync_err_cnt}, {1'b1, 23'd0, 8'd2});
    send_frame(BAD);
    chk("loss_unlocked", {if0.locked, 21'd0, if0.state, if0.sync_err_cnt}, {1'b0, 21'd0, 2'd0, 8'd3});
    idle(10);

    // saturation (dut1 tolerates 14 misses)
    hard_reset();
    send_frame(SYNC);
    send_frame(SYNC);
    for (int r = 0; r < 20; r++) begin
      repeat (14) send_frame(BAD);
      send_frame(SYNC);
      if (r == 17) chk("sat_252", 32'(if1.sync_err_cnt), 32'd252);
    end
    chk("sat_255", 32'(if1.sync_err_cnt), 32'd255);
    chk("sat_locked", 32'(if1.locked), 32'd1);
    idle(10);

    // bit offset
    hard_reset();
    repeat (5) send_bit(1'($urandom_range(0, 1)));
    repeat (3) send_frame(SYNC);
    idle(20);
    chk_words("offset_words");
    chk("offset_locked", 32'(if0.locked), 32'd1);

    // async reset mid-payload
    hard_reset();
    send_frame(SYNC);
    send_frame(SYNC);
    send_word(SYNC);
    send_word(16'h0001);
    for (int i = 15; i >= 8; i--) send_bit(1'(16'h0002 >> i));
    chk("mid_word_before", 32'(if0.word), 32'h0001);
    rst = 1'b1;
    #2;
    chk("mid_rst_outputs", {if0.word, if0.word_valid, if0.frame_start, if0.locked, if0.state, if0.sync_err_cnt},
        32'h0);
    #1;
    rst = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(1'(16'h0002 >> i));
    send_word(16'h0003);
    send_word(16'h0004);
    send_frame(SYNC);
    chk("relock_verify", 32'(if0.state), 32'd1);
    send_frame(SYNC);
    chk("relock_locked", {if0.locked, 29'd0, if0.state}, {1'b1, 29'd0, 2'd2});

    // enable low forces hunt, word held
    en = 1'b0;
    idle(5);
    chk("en_low_hunt", {if0.locked, 29'd0, if0.state}, 32'd0);
    en = 1'b1;
    idle(5);
    // match coinciding with enable falling is dropped
    send_word(SYNC);
    en = 1'b0;
    send_bit(1'b0);
    chk("en_wins_match", 32'(if0.state), 32'd0);
    en = 1'b1;
    idle(20);
    chk("en_stays_hunt", 32'(if0.state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/diff_frame_sync.md
Name: diff_frame_sync

Overview:
- Downstream of the differential clock/data receivers. Runs in the recovered receive-clock domain and takes one serial bit per cycle.
- Hunts for a fixed sync word, confirms it over several frames, then locks.
- Once locked, emits aligned payload words with a valid strobe and reports lock state plus a saturating sync-error count.
- Its parallel outputs feed the 16-bit output pin mux at the top level.

Parameters:
- WORD_W, 16, word and sync-word width in bits (4..32).
- SYNC_WORD, 16'hA55A, framing pattern, MSB first on the wire.
- FRAME_WORDS, 4, payload words following each sync word (1..255).
- LOCK_HITS, 2, consecutive sync matches needed to lock (1..15).
- LOSS_MISSES, 2, consecutive sync misses while locked that drop lock (1..15).

Ports:
- clk  in  1  Recovered receive clock; every rising edge samples one bit.
- rst  in  1  Asynchronous, active-high reset.
- en  in  1  Synchronous enable; low forces the hunt state.
- data_in  in  1  Serial data bit from the data receiver.
- word  out  WORD_W  Last emitted aligned payload word.
- word_valid  out  1  One-cycle strobe; `word` is new this cycle.
- frame_start  out  1  Asserted together with word_valid for payload word 1 of each frame.
- locked  out  1  High in LOCKED state.
- state  out  2  Current state: 0=HUNT, 1=VERIFY, 2=LOCKED.
- sync_err_cnt  out  8  Sync-slot mismatches seen while LOCKED; saturates at 255.

Behaviour:
- Reset (async, rst=1):
  - sr, word, word_valid, frame_start, locked, sync_err_cnt, phase, slot, hit_cnt and miss_cnt all go to 0.
  - State goes to HUNT.
- Shift register: sr <= {sr[WORD_W-2:0], data_in} every cycle, including when en=0. All comparisons use the registered sr.
- Boundary: a cycle where phase==WORD_W-1 and state≠HUNT.
  - phase counts mod WORD_W. It is loaded with 0 on the cycle after a HUNT match, so the next boundary falls exactly WORD_W cycles after the match.
  - slot counts boundaries mod (FRAME_WORDS+1). Slot 0 is the sync slot; slots 1..FRAME_WORDS are payload.
- HUNT:
  - Compare sr to SYNC_WORD every cycle.
  - On match: slot←1, phase←0, hit_cnt←1. Next state is LOCKED if LOCK_HITS==1, else VERIFY.
- VERIFY, at a sync-slot boundary:
  - sr==SYNC_WORD: hit_cnt++. On reaching LOCK_HITS, go to LOCKED and set miss_cnt←0.
  - Mismatch: go to HUNT, hit_cnt←0.
  - Payload boundaries in VERIFY produce no output.
- LOCKED, at a sync-slot boundary:
  - Match: miss_cnt←0.
  - Mismatch: miss_cnt++ and sync_err_cnt++ (saturating at 255). When miss_cnt reaches LOSS_MISSES, go to HUNT.
  - Alignment is not changed on a miss.
- LOCKED, at a payload boundary: word←sr and word_valid←1 on the next edge (latency 1 cycle after the boundary). frame_start←1 when the slot was 1.
- word holds its value between strobes. word_valid and frame_start are single-cycle.
- locked and state are registered. They change on the same edge as the state transition.
- en=0: next state HUNT; hit_cnt, miss_cnt, slot and phase are cleared. word and sync_err_cnt are held; no strobes are generated.
- Simultaneous events:
  - Loss of lock at a sync boundary emits no word on that boundary.
  - A HUNT match on the same cycle as en falling is ignored (en wins).
- Reset mid-frame: everything clears immediately and no partial word is emitted. After release, framing restarts from HUNT.
- Sync patterns appearing inside payload are matched only in HUNT. Payload is not escaped.

Test Plan:
- Lock-up: defaults, three frames of A55A + payload 0001,0002,0003,0004.
  - state goes 0→1 after the first sync, then 1→2 after the second.
  - First valid word is 0001 with frame_start=1, issued 1 cycle after its boundary.
  - Then 0002..0004 follow, spaced 16 cycles apart.
- Verify failure: A55A, then a corrupted sync (A55B) one frame later.
  - state returns to 0.
  - No word_valid ever; sync_err_cnt stays 0.
- Lock loss: lock, then one bad sync followed by a good one.
  - Lock is kept; sync_err_cnt=1; miss_cnt resets.
  - Then two consecutive bad syncs: locked falls after the second, and sync_err_cnt=3.
- Saturation: hold lock with LOSS_MISSES=15 and alternate 14 bad / 1 good syncs for 20 rounds.
  - sync_err_cnt stops at 255; no wrap to 0.
- Bit offset: prepend 5 random bits before the stream. Lock is achieved and the words are correctly aligned (0001..0004).
- Async reset mid-payload: pulse rst for half a cycle while locked.
  - All outputs read 0 immediately and state=0.
  - Relock occurs after two good syncs.
